// File: rtl/battleship_pkg.sv
// Shared Battleship definitions: keypad codes and the entry-sequencer state encoding.
// The keypad scanner and display logic import these too.
package battleship_pkg;

  localparam logic [3:0] KEY_CLR       = 4'hC;
  localparam logic [3:0] KEY_BKSP      = 4'hD;
  localparam logic [3:0] KEY_CONFIRM   = 4'hE;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;

  // Encoding doubles as the display stage code.
  typedef enum logic [2:0] {
    ST_WAIT_ROW     = 3'd0,
    ST_WAIT_COL     = 3'd1,
    ST_WAIT_CONFIRM = 3'd2,
    ST_ISSUE        = 3'd3,
    ST_WAIT_RESULT  = 3'd4,
    ST_DONE         = 3'd5
  } state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/shot_entry_ctrl_timer.sv
// Idle counter for partially entered shots; expired is asserted while enabled
// and the count sits at its terminal value.
module entry_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == LAST);

  // Exact-match terminal count; restart from zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shot_entry_ctrl.sv
// Turn-based keypad sequencer: assembles row/col/confirm into a shot, issues it
// over valid/ready, then applies the hit/miss result to decide the next player.
module shot_entry_ctrl
  import battleship_pkg::*;
#(
  parameter int unsigned GRID           = 8,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned CW             = (GRID > 1) ? $clog2(GRID) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    key_value,
  input  logic          key_valid,
  input  logic          shot_ready,
  input  logic          result_valid,
  input  logic          result_hit,
  input  logic          game_over,
  output logic          shot_valid,
  output logic [CW-1:0] shot_row,
  output logic [CW-1:0] shot_col,
  output logic          shot_player,
  output logic          player,
  output logic [2:0]    stage,
  output logic          err_pulse,
  output logic          timeout_pulse
);

  localparam logic [3:0] GRID_K = 4'(GRID);

  state_e        state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          player_q, player_d;
  logic          shot_player_q, shot_player_d;
  logic          shot_valid_q, shot_valid_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic [2:0]    stage_q;

  logic key_dig, key_legal;
  logic timer_clr, timer_en, timer_expired;

  assign key_dig   = is_digit(key_value);
  assign key_legal = key_dig && (key_value < GRID_K);

  assign timer_en  = (state_q == ST_WAIT_COL) || (state_q == ST_WAIT_CONFIRM);
  assign timer_clr = key_valid || (state_d != state_q);

  entry_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  // Next-state logic; game_over overrides everything, a key beats a timeout.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    player_d      = player_q;
    shot_player_d = shot_player_q;
    err_d         = 1'b0;
    tmo_d         = 1'b0;

    if (game_over) begin
      state_d = ST_DONE;
    end else begin
      unique case (state_q)
        ST_WAIT_ROW: begin
          if (key_valid) begin
            if (key_legal) begin
              row_d   = CW'(key_value);
              state_d = ST_WAIT_COL;
            end else if (key_dig || key_value == KEY_CONFIRM) begin
              err_d = 1'b1;
            end
          end
        end
        ST_WAIT_COL: begin
          if (key_valid) begin
            if (key_legal) begin
              col_d   = CW'(key_value);
              state_d = ST_WAIT_CONFIRM;
            end else if (key_value == KEY_BKSP || key_value == KEY_CLR) begin
              state_d = ST_WAIT_ROW;
            end else if (key_dig || key_value == KEY_CONFIRM) begin
              err_d = 1'b1;
            end
          end else if (timer_expired) begin
            state_d = ST_WAIT_ROW;
            tmo_d   = 1'b1;
          end
        end
        ST_WAIT_CONFIRM: begin
          if (key_valid) begin
            if (key_value == KEY_CONFIRM) begin
              state_d       = ST_ISSUE;
              shot_player_d = player_q;
            end else if (key_value == KEY_BKSP) begin
              state_d = ST_WAIT_COL;
            end else if (key_value == KEY_CLR) begin
              state_d = ST_WAIT_ROW;
            end else if (key_dig) begin
              err_d = 1'b1;
            end
          end else if (timer_expired) begin
            state_d = ST_WAIT_ROW;
            tmo_d   = 1'b1;
          end
        end
        ST_ISSUE: begin
          if (shot_ready) begin
            state_d = ST_WAIT_RESULT;
          end
        end
        ST_WAIT_RESULT: begin
          if (result_valid) begin
            if (!result_hit) begin
              player_d = ~player_q;
            end
            state_d = ST_WAIT_ROW;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_WAIT_ROW;
        end
      endcase
    end

    shot_valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT_ROW;
      row_q         <= '0;
      col_q         <= '0;
      player_q      <= 1'b0;
      shot_player_q <= 1'b0;
      shot_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      tmo_q         <= 1'b0;
      stage_q       <= 3'd0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      player_q      <= player_d;
      shot_player_q <= shot_player_d;
      shot_valid_q  <= shot_valid_d;
      err_q         <= err_d;
      tmo_q         <= tmo_d;
      stage_q       <= 3'(state_d);
    end
  end

  assign shot_valid    = shot_valid_q;
  assign shot_row      = row_q;
  assign shot_col      = col_q;
  assign shot_player   = shot_player_q;
  assign player        = player_q;
  assign stage         = stage_q;
  assign err_pulse     = err_q;
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_shot_entry_ctrl.sv
// Directed bench for shot_entry_ctrl: expected shots are queued when confirmed
// and checked against the DUT at the handshake; inputs change and outputs are sampled on negedge.
module tb_shot_entry_ctrl;

  localparam int unsigned GRID    = 8;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned CW      = 3;

  localparam logic [2:0] S_ROW = 3'd0, S_COL = 3'd1, S_CONF = 3'd2,
                         S_ISS = 3'd3, S_RES = 3'd4, S_DONE = 3'd5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    key_value = 4'h0;
  logic          key_valid = 1'b0;
  logic          shot_ready = 1'b0;
  logic          result_valid = 1'b0;
  logic          result_hit = 1'b0;
  logic          game_over = 1'b0;
  logic          shot_valid;
  logic [CW-1:0] shot_row, shot_col;
  logic          shot_player, player;
  logic [2:0]    stage;
  logic          err_pulse, timeout_pulse;

  typedef struct {
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          plyr;
  } shot_t;

  shot_t sb[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  shot_entry_ctrl #(
    .GRID(GRID),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_value(key_value), .key_valid(key_valid),
    .shot_ready(shot_ready),
    .result_valid(result_valid), .result_hit(result_hit),
    .game_over(game_over),
    .shot_valid(shot_valid), .shot_row(shot_row), .shot_col(shot_col),
    .shot_player(shot_player), .player(player), .stage(stage),
    .err_pulse(err_pulse), .timeout_pulse(timeout_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; key is sampled at the next posedge, returns at the following negedge.
  task automatic press(input logic [3:0] k);
    key_value = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic result(input logic hit);
    result_valid = 1'b1;
    result_hit   = hit;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic push_shot(input logic [CW-1:0] r, input logic [CW-1:0] c, input logic p);
    shot_t e;
    e.row  = r;
    e.col  = c;
    e.plyr = p;
    sb.push_back(e);
  endtask

  // Compares the pending shot against the scoreboard head while valid is high.
  task automatic pop_check(input string tag);
    shot_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    chk({tag, "_valid"}, 32'(shot_valid), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_row"}, 32'(shot_row), 32'(e.row));
      chk({tag, "_col"}, 32'(shot_col), 32'(e.col));
      chk({tag, "_plyr"}, 32'(shot_player), 32'(e.plyr));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(shot_valid), 32'd0);
    chk({tag, "_row"}, 32'(shot_row), 32'd0);
    chk({tag, "_col"}, 32'(shot_col), 32'd0);
    chk({tag, "_splyr"}, 32'(shot_player), 32'd0);
    chk({tag, "_player"}, 32'(player), 32'd0);
    chk({tag, "_stage"}, 32'(stage), 32'(S_ROW));
    chk({tag, "_err"}, 32'(err_pulse), 32'd0);
    chk({tag, "_tmo"}, 32'(timeout_pulse), 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Full shot with ready tied high, then a miss
    shot_ready = 1'b1;
    press(4'd3);
    chk("t1_stage_col", 32'(stage), 32'(S_COL));
    chk("t1_row", 32'(shot_row), 32'd3);
    press(4'd5);
    chk("t1_stage_conf", 32'(stage), 32'(S_CONF));
    chk("t1_col", 32'(shot_col), 32'd5);
    push_shot(3'd3, 3'd5, 1'b0);
    press(4'hE);
    chk("t1_stage_iss", 32'(stage), 32'(S_ISS));
    pop_check("t1");
    @(negedge clk);
    chk("t1_one_cycle", 32'(shot_valid), 32'd0);
    chk("t1_stage_res", 32'(stage), 32'(S_RES));
    result(1'b0);
    chk("t1_player", 32'(player), 32'd1);
    chk("t1_back_row", 32'(stage), 32'(S_ROW));

    // Backpressure for 10 cycles, then a hit
    shot_ready = 1'b0;
    press(4'd2);
    press(4'd7);
    push_shot(3'd2, 3'd7, 1'b1);
    press(4'hE);
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", 32'(shot_valid), 32'd1);
      chk("t2_hold_row", 32'(shot_row), 32'd2);
      chk("t2_hold_col", 32'(shot_col), 32'd7);
      chk("t2_hold_plyr", 32'(shot_player), 32'd1);
      @(negedge clk);
    end
    shot_ready = 1'b1;
    pop_check("t2");
    @(negedge clk);
    chk("t2_valid_low", 32'(shot_valid), 32'd0);
    result(1'b1);
    chk("t2_player_kept", 32'(player), 32'd1);

    // Illegal digit, edit keys, clear
    press(4'd9);
    chk("t3_err", 32'(err_pulse), 32'd1);
    chk("t3_stay_row", 32'(stage), 32'(S_ROW));
    press(4'd4);
    chk("t3_err_clear", 32'(err_pulse), 32'd0);
    press(4'd6);
    chk("t3_col6", 32'(shot_col), 32'd6);
    press(4'hD);
    chk("t3_bksp", 32'(stage), 32'(S_COL));
    press(4'd1);
    chk("t3_col1", 32'(shot_col), 32'd1);
    push_shot(3'd4, 3'd1, 1'b1);
    press(4'hE);
    pop_check("t3");
    @(negedge clk);
    result(1'b0);
    chk("t3_player", 32'(player), 32'd0);
    press(4'd5);
    chk("t3_mid", 32'(stage), 32'(S_COL));
    press(4'hC);
    chk("t3_clr", 32'(stage), 32'(S_ROW));
    chk("t3_clr_noerr", 32'(err_pulse), 32'd0);

    // Idle timeout on cycle 50
    press(4'd4);
    for (int i = 1; i < int'(TIMEOUT); i++) begin
      chk("t4_no_tmo_early", 32'(timeout_pulse), 32'd0);
      @(negedge clk);
    end
    chk("t4_still_col", 32'(stage), 32'(S_COL));
    @(negedge clk);
    chk("t4_tmo", 32'(timeout_pulse), 32'd1);
    chk("t4_tmo_row", 32'(stage), 32'(S_ROW));
    @(negedge clk);
    chk("t4_tmo_pulse", 32'(timeout_pulse), 32'd0);

    // Key on the expiry cycle wins
    press(4'd4);
    repeat (int'(TIMEOUT) - 1) @(negedge clk);
    press(4'd7);
    chk("t4_key_wins_tmo", 32'(timeout_pulse), 32'd0);
    chk("t4_key_wins_stage", 32'(stage), 32'(S_CONF));
    chk("t4_key_wins_col", 32'(shot_col), 32'd7);
    press(4'hC);

    // Keys in WAIT_RESULT and stray result in WAIT_ROW are dropped
    push_shot(3'd1, 3'd2, 1'b0);
    press(4'd1);
    press(4'd2);
    press(4'hE);
    pop_check("t5");
    @(negedge clk);
    press(4'd3);
    chk("t5_drop_stage", 32'(stage), 32'(S_RES));
    chk("t5_drop_err", 32'(err_pulse), 32'd0);
    press(4'hE);
    chk("t5_drop_e_err", 32'(err_pulse), 32'd0);
    result(1'b1);
    chk("t5_hit_row", 32'(stage), 32'(S_ROW));
    result(1'b0);
    chk("t5_stray_stage", 32'(stage), 32'(S_ROW));
    chk("t5_stray_player", 32'(player), 32'd0);
    chk("t5_stray_err", 32'(err_pulse), 32'd0);

    // game_over beats a simultaneous miss
    push_shot(3'd5, 3'd5, 1'b0);
    press(4'd5);
    press(4'd5);
    press(4'hE);
    pop_check("t6");
    @(negedge clk);
    game_over = 1'b1;
    result(1'b0);
    chk("t6_done", 32'(stage), 32'(S_DONE));
    chk("t6_no_toggle", 32'(player), 32'd0);
    chk("t6_valid", 32'(shot_valid), 32'd0);
    press(4'd3);
    chk("t6_key_ignored", 32'(stage), 32'(S_DONE));
    chk("t6_key_noerr", 32'(err_pulse), 32'd0);
    game_over = 1'b0;
    press(4'd3);
    chk("t6_absorbing", 32'(stage), 32'(S_DONE));

    // Reset leaves DONE; then reset mid-ISSUE drops outputs asynchronously
    rst_n = 1'b0;
    @(negedge clk);
    chk("t7_rst_done", 32'(stage), 32'(S_ROW));
    rst_n = 1'b1;
    shot_ready = 1'b0;
    @(negedge clk);
    push_shot(3'd6, 3'd6, 1'b0);
    press(4'd6);
    press(4'd6);
    press(4'hE);
    chk("t7_issue_valid", 32'(shot_valid), 32'd1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs("t7_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_post_valid", 32'(shot_valid), 32'd0);
    chk("t7_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shot_entry_ctrl.md
# shot_entry_ctrl

Turn-based keypad sequencer for the Battleship game. It owns the single shared 4x4 keypad's decoded key stream (`key_value`/`key_valid`) and time-shares it between player 0 and player 1. It assembles a row digit, a column digit and a confirm key into one shot request, and hands the shot to the game-board logic over a valid/ready handshake. It then waits for the hit/miss result and decides whose turn is next. It sits between the keypad scanner and the board/scoring logic.

## Interface
Parameters:
- `GRID`, 8: board edge; digit keys 0..GRID-1 are legal coordinates (GRID ≤ 10).
- `TIMEOUT_CYCLES`, 500_000_000: idle cycles (5 s at 100 MHz) before a partial entry is discarded.
- `CW`, $clog2(GRID): coordinate width (derived).

Ports:
- `clk`  in  1: 100 MHz system clock.
- `rst_n`  in  1: reset. Asynchronous assert, active-low.
- `key_value`  in  4: decoded key code; meaningful only when `key_valid`=1.
- `key_valid`  in  1: one-cycle pulse per accepted key press.
- `shot_ready`  in  1: board logic accepts the shot.
- `result_valid`  in  1: one-cycle pulse carrying the shot outcome.
- `result_hit`  in  1: outcome qualifier; 1 = hit.
- `game_over`  in  1: level signal; the game has ended.
- `shot_valid`  out  1: shot request pending.
- `shot_row`  out  CW: target row.
- `shot_col`  out  CW: target column.
- `shot_player`  out  1: player who fired.
- `player`  out  1: player whose turn it is.
- `stage`  out  3: current state encoding, used for display.
- `err_pulse`  out  1: one-cycle pulse when an illegal key is pressed.
- `timeout_pulse`  out  1: one-cycle pulse when a partial entry is discarded.

## Operation
- Key codes:
  - 0..9 are digits.
  - `C` = clear: return to `WAIT_ROW`.
  - `D` = backspace: go back one stage.
  - `E` = confirm.
  - `A`, `B`, `F` are ignored, with no error.
- States: `WAIT_ROW`, `WAIT_COL`, `WAIT_CONFIRM`, `ISSUE`, `WAIT_RESULT`, `DONE`.
- `WAIT_ROW`:
  - A digit < GRID latches `shot_row` and moves to `WAIT_COL`.
  - A digit ≥ GRID, or `E`, raises `err_pulse` and stays.
  - `D` and `C` are no-ops.
- `WAIT_COL`:
  - A legal digit latches `shot_col` and moves to `WAIT_CONFIRM`.
  - `D` or `C` returns to `WAIT_ROW`.
  - An illegal digit or `E` raises `err_pulse`.
- `WAIT_CONFIRM`:
  - `E` moves to `ISSUE`.
  - `D` returns to `WAIT_COL`.
  - `C` returns to `WAIT_ROW`.
  - Any digit raises `err_pulse`.
- `ISSUE`:
  - `shot_valid`=1.
  - `shot_row`, `shot_col` and `shot_player` are held stable.
  - On `shot_valid && shot_ready`, move to `WAIT_RESULT`.
- `WAIT_RESULT`: on `result_valid`:
  - Miss (`result_hit`=0) toggles `player`.
  - Hit keeps `player`.
  - Both go to `WAIT_ROW`.
- `DONE`: absorbing; only reset leaves it.
- `game_over`=1 in any state forces `DONE` on the next edge and clears `shot_valid`. `game_over` has priority over a simultaneous `result_valid` or key.
- Keys arriving in `ISSUE`, `WAIT_RESULT` or `DONE` are dropped silently, with no `err_pulse`.
- `result_valid` outside `WAIT_RESULT` is ignored.
- Timeout:
  - The counter runs only in `WAIT_COL` and `WAIT_CONFIRM`.
  - It clears on any `key_valid` and on every state change.
  - When the count reaches TIMEOUT_CYCLES-1: go to `WAIT_ROW`, pulse `timeout_pulse`, clear the counter.
  - A key arriving on that same cycle wins, and no timeout is raised.

## Timing
- All outputs are registered.
- Reset values:
  - State = `WAIT_ROW`, `player`=0, `shot_player`=0.
  - `shot_row`=0, `shot_col`=0.
  - `shot_valid`=0, `err_pulse`=0, `timeout_pulse`=0.
  - `stage`=0.
- A key sampled at edge N is reflected in state, coordinates and `err_pulse` after edge N, i.e. one-cycle latency.
- `shot_valid` rises in the first cycle after the `E` key is sampled. It stays high until the cycle in which `shot_ready`=1 is sampled, and falls after that edge.
- `shot_player` is captured from `player` on entry to `ISSUE`.
- The turn change is visible on `player` one cycle after `result_valid`.
- A reset asserted mid-handshake drops `shot_valid` asynchronously. No shot is recorded.
- Counter width is $clog2(TIMEOUT_CYCLES). Comparison is exact-equality; there is no wrap.

## Structure
- Shared package `battleship_pkg` holds:
  - Key code constants `KEY_CLR`=4'hC, `KEY_BKSP`=4'hD, `KEY_CONFIRM`=4'hE.
  - The state encoding.
- The keypad scanner and the display logic reuse these definitions.
- One sub-module, `entry_timer`: a loadable idle counter with inputs `clr` and `en`, and output `expired`. It is parameterised by TIMEOUT_CYCLES.
- The FSM and coordinate registers live in the top module.

## Test plan
Run with TIMEOUT_CYCLES=50.
- Full shot: keys 3, 5, E with `shot_ready` tied 1 → exactly one cycle with `shot_valid`=1, `shot_row`=3, `shot_col`=5, `shot_player`=0. Then a `result_valid` miss → `player`=1.
- Hit keeps turn and ready backpressure: keys 2, 7, E with `shot_ready`=0 for 10 cycles → `shot_valid` high and coordinates stable for 10 cycles. Then `shot_ready`=1 and a hit → `player` unchanged.
- Edit keys and errors:
  - Keys 9 (GRID=8) → `err_pulse`, still `WAIT_ROW`.
  - Then 4, 6, D, 1, E → shot (4,1).
  - Then C mid-entry → `WAIT_ROW`.
- Timeout: key 4, then 50 idle cycles → `timeout_pulse` on cycle 50 and `WAIT_ROW`. A key landing on cycle 50 → no timeout; the key is processed.
- Dropped input: keys during `WAIT_RESULT`, and a stray `result_valid` in `WAIT_ROW` → no state change, no `err_pulse`.
- `game_over` asserted together with `result_valid` → `DONE`, `player` not toggled, all further keys ignored. `rst_n` low mid-`ISSUE` → all outputs return to reset values immediately.
